// File: rtl/conditional_logic.sv
// ARM condition-check unit: holds N,Z,C,V and gates the decoder's PC, register
// and memory write requests by the instruction's condition field.
module conditional_logic (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic [1:0] flag_w,
  input  logic       pcs,
  input  logic       reg_w,
  input  logic       mem_w,
  input  logic       no_write,
  output logic       pc_src,
  output logic       reg_write,
  output logic       mem_write,
  output logic [3:0] flags,
  output logic       cond_ex
);

  logic [1:0] nz_q;
  logic [1:0] cv_q;
  logic       n_f, z_f, c_f, v_f;
  logic       cond_pass;
  logic       nz_we;
  logic       cv_we;

  assign flags = {nz_q, cv_q};
  assign {n_f, z_f, c_f, v_f} = flags;

  // Evaluated against stored flags only, so an instruction that writes flags
  // sees the values left by its predecessor.
  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      4'b0000: cond_pass = z_f;
      4'b0001: cond_pass = ~z_f;
      4'b0010: cond_pass = c_f;
      4'b0011: cond_pass = ~c_f;
      4'b0100: cond_pass = n_f;
      4'b0101: cond_pass = ~n_f;
      4'b0110: cond_pass = v_f;
      4'b0111: cond_pass = ~v_f;
      4'b1000: cond_pass = ~z_f & c_f;
      4'b1001: cond_pass = z_f | ~c_f;
      4'b1010: cond_pass = (n_f == v_f);
      4'b1011: cond_pass = (n_f != v_f);
      4'b1100: cond_pass = ~z_f & (n_f == v_f);
      4'b1101: cond_pass = z_f | (n_f != v_f);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  assign cond_ex   = rst_n & cond_pass;
  assign pc_src    = pcs & cond_ex;
  assign reg_write = reg_w & cond_ex & ~no_write;
  assign mem_write = mem_w & cond_ex;

  assign nz_we = flag_w[1] & cond_ex;
  assign cv_we = flag_w[0] & cond_ex;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nz_q <= 2'b00;
    end else if (nz_we) begin
      nz_q <= alu_flags[3:2];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cv_q <= 2'b00;
    end else if (cv_we) begin
      cv_q <= alu_flags[1:0];
    end
  end

endmodule

// File: tb/tb_conditional_logic.sv
// Scoreboard bench for conditional_logic: expectations are queued as stimulus is
// driven and popped when the observed vector {flags, cond_ex, pc_src, reg_write, mem_write} is sampled.
module tb_conditional_logic;

  logic       clk;
  logic       rst_n;
  logic [3:0] cond;
  logic [3:0] alu_flags;
  logic [1:0] flag_w;
  logic       pcs;
  logic       reg_w;
  logic       mem_w;
  logic       no_write;
  logic       pc_src;
  logic       reg_write;
  logic       mem_write;
  logic [3:0] flags;
  logic       cond_ex;

  typedef struct {
    string      name;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   asserts;
  int   failures;

  conditional_logic dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cond      (cond),
    .alu_flags (alu_flags),
    .flag_w    (flag_w),
    .pcs       (pcs),
    .reg_w     (reg_w),
    .mem_w     (mem_w),
    .no_write  (no_write),
    .pc_src    (pc_src),
    .reg_write (reg_write),
    .mem_write (mem_write),
    .flags     (flags),
    .cond_ex   (cond_ex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, summary not reached");
    $fatal(1);
  end

  function automatic logic [7:0] obs();
    return {flags, cond_ex, pc_src, reg_write, mem_write};
  endfunction

  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cf;
      4'd3:  return !cf;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return !z && cf;
      4'd9:  return z || !cf;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic push(input string name, input logic [7:0] val);
    exp_t x;
    x.name = name;
    x.val  = val;
    sb.push_back(x);
  endtask

  task automatic drive(input logic [3:0] c, input logic [1:0] fw, input logic [3:0] af,
                       input logic p, input logic rw, input logic mw, input logic nw);
    cond = c; flag_w = fw; alu_flags = af; pcs = p; reg_w = rw; mem_w = mw; no_write = nw;
  endtask

  // Loads the flag registers with an unconditional full write.
  task automatic load_flags(input logic [3:0] f);
    @(negedge clk);
    drive(4'b1110, 2'b11, f, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(4'b1110, 2'b00, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    push("reset_hold", 8'b0000_0000);
    e = sb.pop_front(); asserts++;
    if (obs() !== e.val) begin failures++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.val); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    push("reset_release", 8'b0000_1111);
    e = sb.pop_front(); asserts++;
    if (obs() !== e.val) begin failures++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.val); end
  endtask

  task automatic test_cmp_branch();
    load_flags(4'b0000);
    @(negedge clk);
    drive(4'b1110, 2'b11, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0);
    push("cmp_flags", 8'b0110_1000);
    @(posedge clk); #1;
    e = sb.pop_front(); asserts++;
    if (obs() !== e.val) begin failures++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.val); end
    @(negedge clk);
    drive(4'b0000, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    push("beq_taken", 8'b0110_1100);
    #1;
    e = sb.pop_front(); asserts++;
    if (obs() !== e.val) begin failures++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.val); end
    cond = 4'b0001;
    push("bne_not_taken", 8'b0110_0000);
    #1;
    e = sb.pop_front(); asserts++;
    if (obs() !== e.val) begin failures++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.val); end
  endtask

  task automatic test_back_to_back();
    load_flags(4'b0000);
    // CMP with EQ-qualified write: own cond uses old Z=0, so it neither writes nor passes
    @(negedge clk);
    drive(4'b0000, 2'b11, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0);
    push("pre_update_cond", 8'b0000_0000);
    #1;
    e = sb.pop_front(); asserts++;
    if (obs() !== e.val) begin failures++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.val); end
    @(negedge clk);
    drive(4'b1110, 2'b11, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(4'b0000, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    push("b2b_beq", 8'b0100_1100);
    #1;
    e = sb.pop_front(); asserts++;
    if (obs() !== e.val) begin failures++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.val); end
  endtask

  task automatic test_partial_write();
    load_flags(4'b1111);
    @(negedge clk);
    drive(4'b1110, 2'b10, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    push("partial_nz", 8'b0011_1000);
    @(posedge clk); #1;
    e = sb.pop_front(); asserts++;
    if (obs() !== e.val) begin failures++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.val); end
    load_flags(4'b1111);
    @(negedge clk);
    drive(4'b1110, 2'b01, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    push("partial_cv", 8'b1100_1000);
    @(posedge clk); #1;
    e = sb.pop_front(); asserts++;
    if (obs() !== e.val) begin failures++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.val); end
  endtask

  task automatic test_failed_cond();
    load_flags(4'b0000);
    @(negedge clk);
    drive(4'b0000, 2'b11, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b0);
    push("failed_gates", 8'b0000_0000);
    #1;
    e = sb.pop_front(); asserts++;
    if (obs() !== e.val) begin failures++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.val); end
    push("failed_no_flag_write", 8'b0000_0000);
    @(posedge clk); #1;
    e = sb.pop_front(); asserts++;
    if (obs() !== e.val) begin failures++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.val); end
  endtask

  task automatic test_cond_sweep();
    logic m;
    for (int f = 0; f < 16; f++) begin
      load_flags(4'(f));
      for (int c = 0; c < 16; c++) begin
        @(negedge clk);
        drive(4'(c), 2'b00, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0);
        m = ref_cond(4'(c), 4'(f));
        push($sformatf("sweep_f%0h_c%0h", f, c), {4'(f), m, m, m, m});
        #1;
        e = sb.pop_front(); asserts++;
        if (obs() !== e.val) begin failures++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.val); end
      end
    end
  endtask

  task automatic test_no_write();
    load_flags(4'b0000);
    @(negedge clk);
    drive(4'b1110, 2'b11, 4'b1010, 1'b0, 1'b1, 1'b0, 1'b1);
    push("no_write_gate", 8'b0000_1000);
    #1;
    e = sb.pop_front(); asserts++;
    if (obs() !== e.val) begin failures++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.val); end
    push("no_write_flags", 8'b1010_1000);
    @(posedge clk); #1;
    e = sb.pop_front(); asserts++;
    if (obs() !== e.val) begin failures++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.val); end
  endtask

  task automatic test_x_alu();
    load_flags(4'b1001);
    @(negedge clk);
    drive(4'b1110, 2'b00, 4'bxxxx, 1'b0, 1'b0, 1'b0, 1'b0);
    push("x_alu_hold", 8'b1001_1000);
    @(posedge clk); #1;
    e = sb.pop_front(); asserts++;
    if (obs() !== e.val) begin failures++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.val); end
  endtask

  task automatic test_async_reset();
    load_flags(4'b1111);
    @(negedge clk);
    drive(4'b1110, 2'b11, 4'b0101, 1'b1, 1'b1, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    push("async_clear", 8'b0000_0000);
    e = sb.pop_front(); asserts++;
    if (obs() !== e.val) begin failures++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.val); end
    push("reset_beats_write", 8'b0000_0000);
    @(posedge clk); #1;
    e = sb.pop_front(); asserts++;
    if (obs() !== e.val) begin failures++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.val); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    push("release_no_write", 8'b0000_1111);
    e = sb.pop_front(); asserts++;
    if (obs() !== e.val) begin failures++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.val); end
    push("first_edge_write", 8'b0101_1111);
    @(posedge clk); #1;
    e = sb.pop_front(); asserts++;
    if (obs() !== e.val) begin failures++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.val); end
  endtask

  initial begin
    asserts  = 0;
    failures = 0;
    test_reset();
    test_cmp_branch();
    test_back_to_back();
    test_partial_write();
    test_failed_cond();
    test_cond_sweep();
    test_no_write();
    test_x_alu();
    test_async_reset();
    asserts++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule

// File: doc/conditional_logic.md
Name: conditional_logic

Overview:
- Downstream consumer of the decoder's PCS, RegW and MemW signals in the single-cycle ARM control unit.
- Holds the architectural condition flags N, Z, C, V in registers and evaluates the instruction's 4-bit cond field against them.
- Gates PCS, RegW and MemW into the PCSrc, RegWrite and MemWrite signals that drive the datapath.

Parameters:
- None. All widths are fixed by the ARM ISA.

Ports:
- clk        input   1  system clock; rising edge active.
- rst_n      input   1  asynchronous, active-low reset.
- cond       input   4  Instr[31:28] condition field.
- alu_flags  input   4  ALU flags {N,Z,C,V}, bit 3 = N.
- flag_w     input   2  decoder flag-write request; [1] = N,Z; [0] = C,V.
- pcs        input   1  decoder PC-write request.
- reg_w      input   1  decoder register-write request.
- mem_w      input   1  decoder memory-write request.
- no_write   input   1  decoder suppress-register-write (CMP/CMN/TST/TEQ).
- pc_src     output  1  gated PC source select.
- reg_write  output  1  gated register file write enable.
- mem_write  output  1  gated data memory write enable.
- flags      output  4  stored flags {N,Z,C,V}.
- cond_ex    output  1  condition-pass indicator.

Behaviour:
- Clock and reset: one clock (clk). Reset rst_n is asynchronous and active-low.
- Reset:
  - rst_n low clears flags to 4'b0000 immediately, with no clock edge needed.
  - While rst_n is low, pc_src, reg_write, mem_write and cond_ex are forced to 0.
- Flag registers are split in two banks:
  - flags[3:2] (N,Z) load alu_flags[3:2] on a rising clk when flag_w[1] & cond_ex.
  - flags[1:0] (C,V) load alu_flags[1:0] on a rising clk when flag_w[0] & cond_ex.
  - A bank whose enable is low holds its value.
- cond_ex is combinational from cond and the stored flags, never from alu_flags:
  - 0000 EQ: Z
  - 0001 NE: !Z
  - 0010 CS: C
  - 0011 CC: !C
  - 0100 MI: N
  - 0101 PL: !N
  - 0110 VS: V
  - 0111 VC: !V
  - 1000 HI: !Z & C
  - 1001 LS: Z | !C
  - 1010 GE: N == V
  - 1011 LT: N != V
  - 1100 GT: !Z & (N == V)
  - 1101 LE: Z | (N != V)
  - 1110 AL: 1
  - 1111 (unsupported): 0
- Gated outputs are combinational, with zero latency from inputs:
  - pc_src = pcs & cond_ex
  - reg_write = reg_w & cond_ex & !no_write
  - mem_write = mem_w & cond_ex
- Timing:
  - Flag update latency is one cycle: new flags become visible on `flags` and in cond_ex after the rising edge.
  - In the cycle an instruction writes flags, its own cond_ex uses the pre-update flags.
  - Back-to-back case: a CMP followed by BEQ in the next cycle evaluates BEQ against the CMP result.
- Boundary conditions:
  - A failed condition blocks the flag write as well as all three gated enables.
  - flag_w = 2'b01 or 2'b10 updates only the selected bank; the other bank is unchanged.
  - Reset asserted mid-cycle overrides any pending flag write on the same edge.
  - Releasing reset does not cause a flag write until the next qualifying edge.
  - X on alu_flags when both flag_w bits are low must not propagate into flags.

Test Plan:
- Reset: rst_n=0 with pcs=1, reg_w=1, mem_w=1, cond=1110 -> flags=0000 and all gated outputs 0. Release rst_n -> pc_src=1, reg_write=1, mem_write=1.
- Compare then branch:
  - Cycle 0: cond=1110, flag_w=11, alu_flags=0110 -> after edge, flags=0110.
  - Cycle 1: cond=0000 (EQ), pcs=1 -> pc_src=1.
  - Cycle 1 with cond=0001 (NE) instead -> pc_src=0.
- Partial flag write: flags=1111, then flag_w=10 with alu_flags=0000 -> flags=0011.
- Failed condition blocks writes: flags=0000, cond=0000, flag_w=11, reg_w=1, mem_w=1, alu_flags=1111 -> reg_write=0, mem_write=0, and flags remain 0000 after the edge.
- Condition sweep: for each of the 16 flag values and all 16 cond codes, compare cond_ex against a reference model. Include GE/LT/GT/LE with N=1,V=1 and with N=1,V=0; include cond=1111 -> 0.
- no_write: cond=1110, reg_w=1, no_write=1, flag_w=11 -> reg_write=0 and flags updated.
- Async reset mid-write: assert rst_n between edges while flag_w=11 -> flags=0000 immediately and remain 0000 at the next edge.
